// File: rtl/paridade_pkg.sv
// Shared defaults, index/state types and the parity reset constant for arbitro_paridade.
// ARBITRO_PARIDADE_IMPAR_EN selects odd parity, which also changes the parity reset value.
package paridade_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 4;

   typedef logic [$clog2(N_REQ_DEF)-1:0] grant_idx_t;

   typedef enum logic {
      VAZIO = 1'b0,
      CHEIO = 1'b1
   } estado_t;

`ifdef ARBITRO_PARIDADE_IMPAR_EN
   localparam logic PARIDADE_RESET = 1'b1;
`else
   localparam logic PARIDADE_RESET = 1'b0;
`endif

endpackage

// File: rtl/arbitro_paridade_if.sv
// Request and output-slot handshake bundle shared by the arbiter and its producers/consumer.
interface arbitro_paridade_if
   import paridade_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
);

   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ*W-1:0]       req_data;
   logic [N_REQ-1:0]         req_ready;
   logic                     out_valid;
   logic                     out_ready;
   logic [W-1:0]             out_data;
   logic [$clog2(N_REQ)-1:0] out_grant;
   logic                     out_paridade;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_grant, out_paridade
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_grant, out_paridade
   );

endinterface

// File: rtl/calc_paridade.sv
// Combinational W-bit XOR reduction; ARBITRO_PARIDADE_IMPAR_EN inverts it for odd parity.
module calc_paridade #(
   parameter int W = 4
) (
   input  logic [W-1:0] dado_i,
   output logic         paridade_o
);

`ifdef ARBITRO_PARIDADE_IMPAR_EN
   assign paridade_o = ~(^dado_i);
`else
   assign paridade_o = ^dado_i;
`endif

endmodule

// File: rtl/arbitro_paridade.sv
// Round-robin arbiter feeding one shared parity datapath into a single registered output slot.
// Parity sense is selected by ARBITRO_PARIDADE_IMPAR_EN (default: even parity).
module arbitro_paridade
   import paridade_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
) (
   input logic               clk,
   input logic               reset,
   arbitro_paridade_if.slave bus
);

   localparam int              GW     = $clog2(N_REQ);
   localparam logic [GW-1:0]   ULTIMO = GW'(N_REQ - 1);

   estado_t       estado_q, estado_d;
   logic [W-1:0]  dado_q, dado_d;
   logic [GW-1:0] grant_q, grant_d;
   logic          par_q, par_d;
   logic [GW-1:0] ptr_q, ptr_d;

   logic [GW-1:0]    win_s;
   logic             found_s;
   logic             free_s;
   logic             pega_s;
   logic [N_REQ-1:0] req_ready_s;
   logic [W-1:0]     dado_win_s;
   logic             par_win_s;
   int               soma_s;
   int               cand_s;

   // Scan from ptr downwards in priority so the candidate closest to ptr is written last and wins.
   always_comb begin
      win_s   = '0;
      found_s = 1'b0;
      soma_s  = 0;
      cand_s  = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         soma_s  = int'(ptr_q) + k;
         cand_s  = (soma_s >= N_REQ) ? (soma_s - N_REQ) : soma_s;
         win_s   = bus.req_valid[cand_s] ? GW'(cand_s) : win_s;
         found_s = found_s | bus.req_valid[cand_s];
      end
   end

   assign free_s     = (estado_q == VAZIO) | bus.out_ready;
   assign pega_s     = found_s & free_s & ~reset;
   assign dado_win_s = bus.req_data[win_s*W +: W];

   // One-hot ready for the current winner, gated by slot availability and reset.
   always_comb begin
      req_ready_s        = '0;
      req_ready_s[win_s] = pega_s;
   end

   calc_paridade #(.W(W)) u_calc_paridade (
      .dado_i     (dado_win_s),
      .paridade_o (par_win_s)
   );

   // Slot occupancy, slot contents and pointer next-state.
   always_comb begin
      estado_d = estado_q;
      dado_d   = dado_q;
      grant_d  = grant_q;
      par_d    = par_q;
      ptr_d    = ptr_q;
      case (estado_q)
         VAZIO: begin
            if (pega_s) estado_d = CHEIO;
            else        estado_d = VAZIO;
         end
         CHEIO: begin
            if (bus.out_ready && !pega_s) estado_d = VAZIO;
            else                          estado_d = CHEIO;
         end
         default: estado_d = VAZIO;
      endcase
      if (pega_s) begin
         dado_d  = dado_win_s;
         grant_d = win_s;
         par_d   = par_win_s;
         ptr_d   = (win_s == ULTIMO) ? {GW{1'b0}} : (win_s + GW'(1));
      end else begin
         ptr_d   = ptr_q;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= VAZIO;
         dado_q   <= '0;
         grant_q  <= '0;
         par_q    <= PARIDADE_RESET;
         ptr_q    <= '0;
      end else begin
         estado_q <= estado_d;
         dado_q   <= dado_d;
         grant_q  <= grant_d;
         par_q    <= par_d;
         ptr_q    <= ptr_d;
      end
   end

   assign bus.req_ready    = req_ready_s;
   assign bus.out_valid    = (estado_q == CHEIO);
   assign bus.out_data     = dado_q;
   assign bus.out_grant    = grant_q;
   assign bus.out_paridade = par_q;

endmodule

// File: tb/tb_arbitro_paridade.sv
// Directed bench for arbitro_paridade with hand-computed expectations (even or odd parity build).
module tb_arbitro_paridade;
   import paridade_pkg::*;

`ifdef ARBITRO_PARIDADE_IMPAR_EN
   localparam logic IMPAR = 1'b1;
`else
   localparam logic IMPAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [3:0] rr_dado [4] = '{4'h1, 4'h3, 4'h7, 4'hE};
   logic       rr_par  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic [3:0] rr_ready [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

   arbitro_paridade_if #(.N_REQ(4), .W(4)) bus ();

   arbitro_paridade #(.N_REQ(4), .W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic passo();
      @(posedge clk);
      #1;
   endtask

   task automatic amostra();
      @(negedge clk);
   endtask

   task automatic slot(input string tag, input logic v, input grant_idx_t g,
                       input logic [3:0] d, input logic p);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
      check({tag, "_grant"}, 32'(bus.out_grant), 32'(g));
      check({tag, "_data"},  32'(bus.out_data),  32'(d));
      check({tag, "_par"},   32'(bus.out_paridade), 32'(p));
   endtask

   initial begin
      reset         = 1'b1;
      bus.req_valid = 4'b1111;
      bus.req_data  = 16'hE731;
      bus.out_ready = 1'b0;

      // reset held two cycles with every requester valid
      passo(); amostra();
      check("rst1_ready", 32'(bus.req_ready), 32'h0);
      slot("rst1", 1'b0, 2'd0, 4'h0, IMPAR);
      passo(); amostra();
      check("rst2_ready", 32'(bus.req_ready), 32'h0);
      slot("rst2", 1'b0, 2'd0, 4'h0, IMPAR);

      // round robin, downstream always ready
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("rr_first_ready", 32'(bus.req_ready), 32'h1);
      for (int i = 0; i < 5; i++) begin
         passo(); amostra();
         slot("rr", 1'b1, grant_idx_t'(i % 4), rr_dado[i % 4], rr_par[i % 4] ^ IMPAR);
         check("rr_ready", 32'(bus.req_ready), 32'(rr_ready[i % 4]));
      end

      // backpressure: slot holds requester 0, ptr at 1
      bus.out_ready = 1'b0;
      #1;
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         passo(); amostra();
         check("bp_stall_ready", 32'(bus.req_ready), 32'h0);
         slot("bp_stall", 1'b1, 2'd0, 4'h1, 1'b1 ^ IMPAR);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus.req_ready), 32'h2);
      passo(); amostra();
      slot("bp_refill", 1'b1, 2'd1, 4'h3, 1'b0 ^ IMPAR);

      // parity with requester 2 alone
      bus.req_valid = 4'b0100;
      bus.req_data  = 16'h0B00;
      #1;
      check("par_ready", 32'(bus.req_ready), 32'h4);
      passo(); amostra();
      slot("par_1011", 1'b1, 2'd2, 4'hB, 1'b1 ^ IMPAR);
      bus.req_data = 16'h0600;
      passo(); amostra();
      slot("par_0110", 1'b1, 2'd2, 4'h6, 1'b0 ^ IMPAR);
      bus.req_data = 16'h0000;
      passo(); amostra();
      slot("par_0000", 1'b1, 2'd2, 4'h0, 1'b0 ^ IMPAR);

      // all idle: slot drains, ptr stays at 3
      bus.req_valid = 4'b0000;
      #1;
      check("idle_ready", 32'(bus.req_ready), 32'h0);
      passo(); amostra();
      check("idle_valid", 32'(bus.out_valid), 32'h0);

      // wrap and skip with requesters 1 and 3
      bus.req_valid = 4'b1010;
      bus.req_data  = 16'h50E0;
      #1;
      check("wrap_ready", 32'(bus.req_ready), 32'h8);
      passo(); amostra();
      slot("wrap_g3a", 1'b1, 2'd3, 4'h5, 1'b0 ^ IMPAR);
      check("wrap_ready_g1", 32'(bus.req_ready), 32'h2);
      passo(); amostra();
      slot("wrap_g1", 1'b1, 2'd1, 4'hE, 1'b1 ^ IMPAR);
      passo(); amostra();
      slot("wrap_g3b", 1'b1, 2'd3, 4'h5, 1'b0 ^ IMPAR);

      // reset mid-stall with 4'b1110 from requester 1 in the slot
      bus.req_valid = 4'b0010;
      #1;
      check("rs_ready", 32'(bus.req_ready), 32'h2);
      passo(); amostra();
      bus.out_ready = 1'b0;
      passo(); amostra();
      slot("rs_stall", 1'b1, 2'd1, 4'hE, 1'b1 ^ IMPAR);
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check("rs_reset_ready", 32'(bus.req_ready), 32'h0);
      passo(); amostra();
      slot("rs_after", 1'b0, 2'd0, 4'h0, IMPAR);
      reset         = 1'b0;
      bus.req_valid = 4'b1010;
      #1;
      check("rs_ptr_ready", 32'(bus.req_ready), 32'h2);
      passo(); amostra();
      slot("rs_grant", 1'b1, 2'd1, 4'hE, 1'b1 ^ IMPAR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arbitro_paridade.md
# arbitro_paridade

Round-robin arbiter that shares a single even-parity datapath among `N_REQ` requesters. Each requester offers a `W`-bit word over a valid/ready handshake. One word is granted per cycle. The granted word passes through the parity reduction and is registered into a single-entry output slot, together with the winner's index and the parity bit. The block sits between the nibble producers and the downstream parity consumer/checker.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `W`, 4, data word width in bits (1..16).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  bit i high: requester i offers a word.
- `req_data`  in  N_REQ*W  word of requester i at bits [i*W +: W].
- `req_ready`  out  N_REQ  one-hot or zero; bit i high: word i transfers at this edge.
- `out_valid`  out  1  output slot holds a valid result.
- `out_ready`  in  1  downstream accepts the slot at this edge.
- `out_data`  out  W  registered copy of the granted word.
- `out_grant`  out  clog2(N_REQ)  index of the requester that supplied `out_data`.
- `out_paridade`  out  1  parity bit: XOR reduction of `out_data` (data plus this bit has an even count of ones).

## Operation
- Request transfer: `req_valid[i] & req_ready[i]`. Output transfer: `out_valid & out_ready`.
- Slot free: `free = !out_valid | out_ready`. `req_ready` is all-zero when `free` is 0.
- Arbitration (combinational):
  - Search starts at `ptr` and wraps modulo N_REQ.
  - The first i with `req_valid[i]` wins; `req_ready[i] = free`.
- On a request transfer:
  - The slot loads data, index and parity; `out_valid` becomes 1.
  - `ptr` becomes winner+1 mod N_REQ, wrapping from N_REQ-1 to 0.
- On an output transfer with no request transfer: `out_valid` becomes 0.
- Simultaneous output transfer and request transfer: the slot is overwritten in the same edge, `out_valid` stays 1, and throughput is one word per cycle.
- `ptr` does not move on cycles without a request transfer.
- Requesters keep `req_valid` and `req_data` stable until transfer.
- The arbiter may move a pending grant to a new requester when `free` is 0. This is legal because no transfer occurs.
- States (from `out_valid`):
  - VAZIO → CHEIO on a request transfer.
  - CHEIO → VAZIO on an output transfer with no new request.
  - CHEIO → CHEIO on stall, or on a drain plus refill in the same edge.
- Slot contents stay stable while `out_valid & !out_ready`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_grant`=0, `out_paridade`=0 (1 under the odd-parity option), `ptr`=0.
- `req_ready` is 0 during the reset cycle.
- Latency: a request transfer at edge k gives `out_valid`=1 with the result after edge k.
- `req_ready` depends combinationally on `req_valid`, `ptr`, `out_valid` and `out_ready`.
- `out_*` are registered only.
- Reset mid-operation: the held slot is discarded, `ptr` returns to 0, and no transfer occurs in the reset cycle.
- All requesters idle: `req_ready`=0, and the slot drains normally.
- Single active requester: it transfers every cycle while downstream is ready. Fairness: a continuously requesting requester waits at most N_REQ-1 transfers.

## Configuration
- `ARBITRO_PARIDADE_IMPAR_EN` defined: `out_paridade` is the inverted XOR reduction (odd parity), and its reset value is 1.
- Undefined: even parity as above, reset value 0.
- No other behaviour changes.

## Structure
- Shared package `paridade_pkg` holds:
  - defaults `N_REQ_DEF`=4 and `W_DEF`=4;
  - the `grant_idx_t` index typedef;
  - the `PARIDADE_RESET` constant chosen by the macro.
- One sub-module, `calc_paridade`: a combinational W-bit XOR reduction with the odd option applied. It is instantiated once, on the granted word.
- The arbiter mux and `ptr` stay in the top.

## Test plan
- Reset: hold `reset` 2 cycles with all `req_valid`=1 → `req_ready`=0, `out_valid`=0, `out_*`=0; the first grant after reset goes to requester 0.
- Parity: requester 2 alone sends 4'b1011 → next cycle `out_data`=4'b1011, `out_grant`=2, `out_paridade`=1. Sending 4'b0110 gives 0; sending 4'b0000 gives 0.
- Round robin: all four valid, `out_ready`=1 → grants in order 0,1,2,3,0, one per cycle, with `out_valid` continuously 1.
- Backpressure: `out_ready`=0 for 3 cycles with slot full → `req_ready`=0 and `out_*` stable; on release, the drain and the next grant happen in the same edge.
- Wrap and skip: ptr=3, only requesters 1 and 3 valid → grant 3, then 1, then 3.
- Reset mid-stall: slot holds 4'b1110 from requester 1, assert `reset` → `out_valid`=0 next cycle and `ptr`=0. Repeat with `ARBITRO_PARIDADE_IMPAR_EN` defined → `out_paridade` resets to 1 and 4'b1011 yields 0.
